// File: rtl/vram_pkg.sv
// vram_pkg: beam geometry, framebuffer constants and read-return tags shared by
// the VRAM arbiter slice (optional clear engine enabled by VRAM_ARB_CLEAR_EN).
package vram_pkg;

    localparam int H_RES       = 640;
    localparam int V_RES       = 480;
    localparam int SCALE_SHIFT = 2;
    localparam int ADDR_W      = 15;
    localparam int DATA_W      = 8;
    localparam int POS_W       = 16;

    localparam int SCALE   = 1 << SCALE_SHIFT;
    localparam int FB_W    = H_RES >> SCALE_SHIFT;
    localparam int FB_H    = V_RES >> SCALE_SHIFT;
    localparam int FB_SIZE = FB_W * FB_H;

    // Fetches run one upscaled pixel ahead of the beam, so the slot window
    // starts at -SCALE and stops one pixel group before the right edge.
    localparam logic signed [POS_W-1:0] SX_FIRST = POS_W'(-SCALE);
    localparam logic signed [POS_W-1:0] SX_LAST  = POS_W'(H_RES - SCALE - 1);
    localparam logic signed [POS_W-1:0] SY_FIRST = '0;
    localparam logic signed [POS_W-1:0] SY_LAST  = POS_W'(V_RES - 1);

    localparam logic [SCALE_SHIFT-1:0] PHASE_LAST  = '1;
    localparam logic [ADDR_W-1:0]      FB_W_VEC    = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0]      FB_SIZE_VEC = ADDR_W'(FB_SIZE);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_CPU  = 2'd2
    } tag_t;

    // row*FB_W + col built from constant shifts and adds only.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [ADDR_W-1:0] row,
                                                  input logic [ADDR_W-1:0] col);
        logic [ADDR_W-1:0] acc;
        acc = col;
        for (int i = 0; i < ADDR_W; i++) begin
            if (FB_W_VEC[i]) begin
                acc = acc + (row << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/vram_clear_seq.sv
// vram_clear_seq: address counter and busy flag for the framebuffer clear;
// only instantiated when VRAM_ARB_CLEAR_EN is defined.
module vram_clear_seq
    import vram_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              grant,
    output logic              busy,
    output logic [ADDR_W-1:0] addr
);

    // A start pulse always wins so a clear in progress restarts from zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= 1'b0;
            addr <= '0;
        end else if (start) begin
            busy <= 1'b1;
            addr <= '0;
        end else if (busy && grant) begin
            if (addr == ADDR_W'(FB_SIZE - 1)) begin
                busy <= 1'b0;
            end else begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: time-shares one single-port VRAM between beam-locked scan-out
// fetches, a CPU port and a framebuffer clear engine (macro VRAM_ARB_CLEAR_EN).
module vram_arbiter
    import vram_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [POS_W-1:0]  sx,
    input  logic [POS_W-1:0]  sy,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              clear,
    input  logic [DATA_W-1:0] clear_color,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] pix_data
);

    typedef enum logic {
        CPU_IDLE = 1'b0,
        CPU_BUSY = 1'b1
    } cpu_state_t;

    cpu_state_t              cpu_state;
    cpu_state_t              cpu_state_next;
    logic                    cpu_grant;
    logic                    cpu_oor;
    logic                    cpu_oor_q;
    logic                    clear_grant;
    logic [ADDR_W-1:0]       clear_addr;
    logic signed [POS_W-1:0] sx_pos;
    logic signed [POS_W-1:0] sy_pos;
    logic [SCALE_SHIFT-1:0]  phase;
    logic                    disp_slot;
    logic [ADDR_W-1:0]       slot_addr;
    logic [ADDR_W-1:0]       ram_addr_next;
    logic                    ram_we_next;
    logic [DATA_W-1:0]       ram_wdata_next;
    tag_t                    tag_next;
    tag_t                    tag_issue;
    tag_t                    tag_return;
    logic                    disp_hit;
    logic [DATA_W-1:0]       disp_data;

    assign sx_pos  = sx;
    assign sy_pos  = sy;
    assign phase   = sx[SCALE_SHIFT-1:0];
    assign cpu_oor = (cpu_addr >= FB_SIZE_VEC);

    assign disp_slot = (sy_pos >= SY_FIRST) && (sy_pos <= SY_LAST) &&
                       (sx_pos >= SX_FIRST) && (sx_pos <= SX_LAST) &&
                       (phase == '0);

    assign slot_addr = fb_addr(ADDR_W'(sy >> SCALE_SHIFT),
                               ADDR_W'((sx + POS_W'(SCALE)) >> SCALE_SHIFT));

    // CPU handshake state: BUSY blocks new grants until the ack has been shown.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_state <= CPU_IDLE;
        end else begin
            cpu_state <= cpu_state_next;
        end
    end

    always_comb begin
        cpu_state_next = cpu_state;
        cpu_grant      = 1'b0;
        case (cpu_state)
            CPU_IDLE: begin
                if (cpu_req && !disp_slot) begin
                    cpu_grant      = 1'b1;
                    cpu_state_next = CPU_BUSY;
                end
            end
            CPU_BUSY: begin
                if (cpu_ack) begin
                    cpu_state_next = CPU_IDLE;
                end
            end
            default: cpu_state_next = CPU_IDLE;
        endcase
    end

    // Single-winner port mux: display, then CPU, then clear. Address and data
    // hold when idle; only the write enable must fall.
    always_comb begin
        ram_addr_next  = ram_addr;
        ram_wdata_next = ram_wdata;
        ram_we_next    = 1'b0;
        tag_next       = TAG_NONE;
        clear_grant    = 1'b0;
        if (disp_slot) begin
            ram_addr_next = slot_addr;
            tag_next      = TAG_DISP;
        end else if (cpu_grant) begin
            ram_addr_next  = cpu_addr;
            ram_wdata_next = cpu_wdata;
            ram_we_next    = cpu_we && !cpu_oor;
            tag_next       = cpu_we ? TAG_NONE : TAG_CPU;
        end else if (clear_busy) begin
            clear_grant    = 1'b1;
            ram_addr_next  = clear_addr;
            ram_wdata_next = clear_color;
            ram_we_next    = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            tag_issue  <= TAG_NONE;
            tag_return <= TAG_NONE;
        end else begin
            ram_addr   <= ram_addr_next;
            ram_we     <= ram_we_next;
            ram_wdata  <= ram_wdata_next;
            tag_issue  <= tag_next;
            tag_return <= tag_issue;
        end
    end

    // Writes ack straight after the grant; reads ack once their tag returns.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            cpu_oor_q <= 1'b0;
        end else begin
            cpu_ack <= (cpu_grant && cpu_we) || (tag_return == TAG_CPU);
            if (cpu_grant) begin
                cpu_oor_q <= cpu_oor;
            end
            if (tag_return == TAG_CPU) begin
                cpu_rdata <= cpu_oor_q ? '0 : ram_rdata;
            end
        end
    end

    // Fetched pixel waits one cycle, then is presented on the last phase of
    // the group so it lines up with the following group of beam positions.
    always_ff @(posedge clock) begin
        if (reset) begin
            disp_hit  <= 1'b0;
            disp_data <= '0;
            pix_data  <= '0;
        end else begin
            disp_hit <= (tag_return == TAG_DISP);
            if (tag_return == TAG_DISP) begin
                disp_data <= ram_rdata;
            end
            if (phase == PHASE_LAST) begin
                pix_data <= disp_hit ? disp_data : '0;
            end
        end
    end

`ifdef VRAM_ARB_CLEAR_EN
    vram_clear_seq u_clear_seq (
        .clock (clock),
        .reset (reset),
        .start (clear),
        .grant (clear_grant),
        .busy  (clear_busy),
        .addr  (clear_addr)
    );
`else
    logic clear_unused;
    assign clear_unused = clear ^ clear_grant;
    assign clear_busy   = 1'b0;
    assign clear_addr   = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed vectors plus hand-written sequences for vram_arbiter
// against a 1-cycle-latency RAM model (clear tests need VRAM_ARB_CLEAR_EN).
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int MEM_DEPTH = 1 << ADDR_W;
    localparam int BLANK_X   = 700;
    localparam int BLANK_Y   = 500;

    logic              clock = 1'b0;
    logic              reset;
    logic [POS_W-1:0]  sx;
    logic [POS_W-1:0]  sy;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              clear;
    logic [DATA_W-1:0] clear_color;
    logic              clear_busy;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] pix_data;

    logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];
    logic [DATA_W-1:0] exp_mem [0:MEM_DEPTH-1];
    logic              mem_wipe;
    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [DATA_W-1:0] bd_data;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        int   sx;
        int   sy;
        logic slot;
        int   addr;
    } vec_t;

    vec_t vecs [14];

    vram_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .sx          (sx),
        .sy          (sy),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .clear       (clear),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .pix_data    (pix_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_wipe) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int x, input int y, input logic req,
                                 input logic we, input int addr, input int wdata);
        @(negedge clock);
        sx        = POS_W'(x);
        sy        = POS_W'(y);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = ADDR_W'(addr);
        cpu_wdata = DATA_W'(wdata);
    endtask

    task automatic stepBlank(input int n);
        for (int i = 0; i < n; i++) applyStimulus(BLANK_X, BLANK_Y, 1'b0, 1'b0, 0, 0);
    endtask

    // Issues one CPU access in blanking; lat counts cycles from grant to ack.
    task automatic cpuAccess(input logic we, input int addr, input int wdata,
                             output logic [DATA_W-1:0] rdata, output int lat,
                             output logic we_seen);
        lat     = 0;
        we_seen = 1'b0;
        rdata   = '0;
        applyStimulus(BLANK_X, BLANK_Y, 1'b1, we, addr, wdata);
        for (int n = 1; n <= 10; n++) begin
            applyStimulus(BLANK_X, BLANK_Y, 1'b1, we, addr, wdata);
            we_seen = we_seen | ram_we;
            lat     = n;
            if (cpu_ack) begin
                rdata = cpu_rdata;
                break;
            end
        end
        applyStimulus(BLANK_X, BLANK_Y, 1'b0, 1'b0, 0, 0);
        we_seen = we_seen | ram_we;
        if (we && addr < FB_SIZE) exp_mem[addr] = DATA_W'(wdata);
    endtask

    function automatic logic isSlot(input int x, input int y);
        return (y >= 0) && (y < V_RES) && (x >= -SCALE) && (x < H_RES - SCALE) &&
               ((x % SCALE) == 0);
    endfunction

    initial begin
        logic [DATA_W-1:0] rd;
        int                lat;
        logic              wseen;

        vecs[0]  = '{-4,   0,   1'b1, 0};
        vecs[1]  = '{0,    0,   1'b1, 1};
        vecs[2]  = '{632,  0,   1'b1, 159};
        vecs[3]  = '{636,  0,   1'b0, 0};
        vecs[4]  = '{-8,   0,   1'b0, 0};
        vecs[5]  = '{1,    0,   1'b0, 0};
        vecs[6]  = '{-4,   479, 1'b1, 19040};
        vecs[7]  = '{632,  479, 1'b1, 19199};
        vecs[8]  = '{0,    480, 1'b0, 0};
        vecs[9]  = '{0,    -1,  1'b0, 0};
        vecs[10] = '{4,    4,   1'b1, 162};
        vecs[11] = '{-3,   4,   1'b0, 0};
        vecs[12] = '{628,  7,   1'b1, 318};
        vecs[13] = '{-1,   100, 1'b0, 0};

        for (int i = 0; i < MEM_DEPTH; i++) exp_mem[i] = '0;
        reset       = 1'b1;
        mem_wipe    = 1'b1;
        bd_we       = 1'b0;
        bd_addr     = '0;
        bd_data     = '0;
        clear       = 1'b0;
        clear_color = '0;
        sx          = POS_W'(BLANK_X);
        sy          = POS_W'(BLANK_Y);
        cpu_req     = 1'b0;
        cpu_we      = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = '0;
        stepBlank(3);
        checkOutput("reset_ram_addr", ram_addr, 0);
        checkOutput("reset_ram_we", ram_we, 0);
        checkOutput("reset_cpu_ack", cpu_ack, 0);
        checkOutput("reset_pix", pix_data, 0);
        checkOutput("reset_clear_busy", clear_busy, 0);
        reset    = 1'b0;
        mem_wipe = 1'b0;
        stepBlank(2);

        // Slot decode table: a pending CPU write loses only to a display slot.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].sx, vecs[i].sy, 1'b1, 1'b1, 19000, 8'h5A);
            applyStimulus(BLANK_X, BLANK_Y, 1'b0, 1'b0, 0, 0);
            checkOutput($sformatf("vec%0d_ram_addr", i), ram_addr,
                        vecs[i].slot ? vecs[i].addr : 19000);
            checkOutput($sformatf("vec%0d_ram_we", i), ram_we, !vecs[i].slot);
            checkOutput($sformatf("vec%0d_cpu_ack", i), cpu_ack, !vecs[i].slot);
            if (!vecs[i].slot) exp_mem[19000] = 8'h5A;
            stepBlank(3);
        end

        // Write then read address 0 with exact latencies.
        applyStimulus(BLANK_X, BLANK_Y, 1'b1, 1'b1, 0, 8'hA5);
        applyStimulus(BLANK_X, BLANK_Y, 1'b1, 1'b1, 0, 8'hA5);
        checkOutput("wr_ack_g1", cpu_ack, 1);
        checkOutput("wr_ram_we_g1", ram_we, 1);
        checkOutput("wr_ram_addr_g1", ram_addr, 0);
        checkOutput("wr_ram_wdata_g1", ram_wdata, 8'hA5);
        applyStimulus(BLANK_X, BLANK_Y, 1'b0, 1'b0, 0, 0);
        checkOutput("wr_ack_g2", cpu_ack, 0);
        exp_mem[0] = 8'hA5;
        applyStimulus(BLANK_X, BLANK_Y, 1'b1, 1'b0, 0, 0);
        applyStimulus(BLANK_X, BLANK_Y, 1'b1, 1'b0, 0, 0);
        checkOutput("rd_ack_g1", cpu_ack, 0);
        checkOutput("rd_ram_we_g1", ram_we, 0);
        applyStimulus(BLANK_X, BLANK_Y, 1'b1, 1'b0, 0, 0);
        checkOutput("rd_ack_g2", cpu_ack, 0);
        applyStimulus(BLANK_X, BLANK_Y, 1'b1, 1'b0, 0, 0);
        checkOutput("rd_ack_g3", cpu_ack, 1);
        checkOutput("rd_data_g3", cpu_rdata, 8'hA5);
        applyStimulus(BLANK_X, BLANK_Y, 1'b0, 1'b0, 0, 0);
        checkOutput("rd_ack_g4", cpu_ack, 0);
        checkOutput("rd_data_held", cpu_rdata, 8'hA5);
        stepBlank(2);

        // Reset in G+1 of a read drops it without an ack.
        cpuAccess(1'b1, 161, 8'h3C, rd, lat, wseen);
        checkOutput("wr161_lat", lat, 1);
        applyStimulus(BLANK_X, BLANK_Y, 1'b1, 1'b0, 161, 8'h99);
        applyStimulus(BLANK_X, BLANK_Y, 1'b1, 1'b0, 161, 8'h99);
        checkOutput("rst_pre_addr", ram_addr, 161);
        reset = 1'b1;
        applyStimulus(BLANK_X, BLANK_Y, 1'b0, 1'b0, 0, 0);
        reset = 1'b0;
        checkOutput("rst_ram_addr", ram_addr, 0);
        checkOutput("rst_ram_we", ram_we, 0);
        checkOutput("rst_ram_wdata", ram_wdata, 0);
        checkOutput("rst_cpu_ack", cpu_ack, 0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 0);
        checkOutput("rst_pix", pix_data, 0);
        checkOutput("rst_clear_busy", clear_busy, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(BLANK_X, BLANK_Y, 1'b0, 1'b0, 0, 0);
            checkOutput("rst_no_ack", cpu_ack, 0);
        end
        cpuAccess(1'b0, 161, 0, rd, lat, wseen);
        checkOutput("rerd_lat", lat, 3);
        checkOutput("rerd_data", rd, 8'h3C);

        // Out-of-range accesses are acked but never touch the RAM.
        @(negedge clock);
        bd_we   = 1'b1;
        bd_addr = ADDR_W'(FB_SIZE);
        bd_data = 8'hEE;
        @(negedge clock);
        bd_we = 1'b0;
        cpuAccess(1'b1, FB_SIZE, 8'h55, rd, lat, wseen);
        checkOutput("oor_wr_lat", lat, 1);
        checkOutput("oor_wr_we_seen", wseen, 0);
        cpuAccess(1'b0, FB_SIZE, 0, rd, lat, wseen);
        checkOutput("oor_rd_lat", lat, 3);
        checkOutput("oor_rd_data", rd, 0);

        // CPU request held over a display slot waits exactly one cycle.
        applyStimulus(-4, 0, 1'b1, 1'b1, 500, 8'h42);
        applyStimulus(-3, 0, 1'b1, 1'b1, 500, 8'h42);
        checkOutput("defer_ram_addr", ram_addr, 0);
        checkOutput("defer_ram_we", ram_we, 0);
        checkOutput("defer_ack", cpu_ack, 0);
        applyStimulus(-2, 0, 1'b1, 1'b1, 500, 8'h42);
        checkOutput("defer_grant_addr", ram_addr, 500);
        checkOutput("defer_grant_we", ram_we, 1);
        checkOutput("defer_grant_ack", cpu_ack, 1);
        exp_mem[500] = 8'h42;
        applyStimulus(-1, 0, 1'b0, 1'b0, 0, 0);
        stepBlank(3);

        // Scan line 4 (framebuffer row 1) with a few known pixels.
        cpuAccess(1'b1, 160, 8'h21, rd, lat, wseen);
        cpuAccess(1'b1, 162, 8'h5A, rd, lat, wseen);
        cpuAccess(1'b1, 319, 8'h77, rd, lat, wseen);
        checkOutput("wr319_we_seen", wseen, 1);
        for (int x = -16; x <= 660; x++) begin
            applyStimulus(x, 4, 1'b0, 1'b0, 0, 0);
            if (x >= -8) begin
                checkOutput($sformatf("pix_sx%0d", x), pix_data,
                            (x >= 0 && x < H_RES) ? exp_mem[FB_W + (x >> SCALE_SHIFT)] : 0);
            end
        end
        stepBlank(4);

`ifdef VRAM_ARB_CLEAR_EN
        begin
            int   px;
            int   py;
            int   cycles;
            int   writes;
            int   disp_bad;
            int   color_bad;
            int   mem_bad;
            logic prev_slot;
            int   prev_addr;
            logic prev_busy;
            logic last_seen;
            logic busy_at_last;
            logic busy_before_last;

            px = -16; py = 0;
            writes = 0; disp_bad = 0; color_bad = 0; mem_bad = 0;
            last_seen = 1'b0; busy_at_last = 1'b1; busy_before_last = 1'b0;
            clear_color = 8'h11;
            clear = 1'b1;
            applyStimulus(px, py, 1'b0, 1'b0, 0, 0);
            checkOutput("clr_busy_before", clear_busy, 0);
            prev_slot = isSlot(px, py);
            prev_addr = (py >> SCALE_SHIFT) * FB_W + ((px + SCALE) >> SCALE_SHIFT);
            prev_busy = clear_busy;
            clear = 1'b0;
            cycles = 0;
            while (cycles < 60000) begin
                px++;
                if (px > 783) begin
                    px = -16;
                    py = (py == 524) ? 0 : py + 1;
                end
                applyStimulus(px, py, 1'b0, 1'b0, 0, 0);
                cycles++;
                if (cycles == 1) checkOutput("clr_busy_rise", clear_busy, 1);
                if (prev_slot && (ram_addr != ADDR_W'(prev_addr) || ram_we)) disp_bad++;
                if (ram_we) begin
                    writes++;
                    if (ram_wdata != 8'h11) color_bad++;
                    if (ram_addr == ADDR_W'(FB_SIZE - 1)) begin
                        last_seen        = 1'b1;
                        busy_at_last     = clear_busy;
                        busy_before_last = prev_busy;
                    end
                end
                prev_slot = isSlot(px, py);
                prev_addr = (py >> SCALE_SHIFT) * FB_W + ((px + SCALE) >> SCALE_SHIFT);
                prev_busy = clear_busy;
                if (!clear_busy && !ram_we && cycles > 1) break;
            end
            checkOutput("clr_finished", (cycles < 60000), 1);
            checkOutput("clr_disp_delayed", disp_bad, 0);
            checkOutput("clr_color_bad", color_bad, 0);
            checkOutput("clr_writes", writes, FB_SIZE);
            checkOutput("clr_last_seen", last_seen, 1);
            checkOutput("clr_busy_at_last", busy_at_last, 0);
            checkOutput("clr_busy_before_last", busy_before_last, 1);
            stepBlank(2);
            for (int a = 0; a < FB_SIZE; a++) if (mem[a] != 8'h11) mem_bad++;
            checkOutput("clr_mem_bad", mem_bad, 0);
            checkOutput("clr_mem_oor", mem[FB_SIZE], 8'hEE);
        end
`else
        clear_color = 8'h11;
        clear = 1'b1;
        applyStimulus(BLANK_X, BLANK_Y, 1'b0, 1'b0, 0, 0);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(BLANK_X, BLANK_Y, 1'b0, 1'b0, 0, 0);
            checkOutput("noclr_busy", clear_busy, 0);
            checkOutput("noclr_we", ram_we, 0);
        end
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
